axi4_id_compactor: RTL and testbench

- Upstream neighbour of the per-ID user-field queue block (four 7-bit queues per direction, indexed by a 2-bit ID).
- Maps wide master IDs (IN_ID_W bits) onto NUM_SLOTS compact downstream IDs, and restores the original ID on responses.
- Responses that share a master ID keep their order, because they share a slot.
- One instance serves AR/R (resp_last = RLAST). A second serves AW/B (resp_last tied 1).

---
 rtl/axi4_id_compactor.sv | 143 ++++++++++++++
 tb/tb_axi4_id_compactor.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_id_compactor.sv
// axi4_id_compactor
// Maps wide upstream AXI IDs onto NUM_SLOTS compact downstream IDs and
// restores the original ID on the response path. Requests sharing an
// upstream ID share a slot, so their responses stay in order downstream.
//
// Optional feature macro: AXI4_ID_COMPACTOR_STATS_EN (adds stall_cnt).
//
// Ports:
//   clock, reset_n          clock / async active-low reset
//   in_req_*                upstream request (valid/ready/id/bits)
//   out_req_*               downstream request, id = slot index
//   out_resp_*              downstream response (valid/ready/id/last/bits)
//   in_resp_*               upstream response, id restored from slot tag
//   err_underflow           sticky: last-response on an idle slot
//   stall_cnt               (stats build only) saturating stall-cycle count
module axi4_id_compactor #(
    parameter int IN_ID_W = 7,
    parameter int SLOT_W  = 2,
    parameter int CNT_W   = 3,
    parameter int REQ_W   = 32,
    parameter int RESP_W  = 34
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                in_req_valid,
    output logic                in_req_ready,
    input  logic [IN_ID_W-1:0]  in_req_id,
    input  logic [REQ_W-1:0]    in_req_bits,
    output logic                out_req_valid,
    input  logic                out_req_ready,
    output logic [SLOT_W-1:0]   out_req_id,
    output logic [REQ_W-1:0]    out_req_bits,
    input  logic                out_resp_valid,
    output logic                out_resp_ready,
    input  logic [SLOT_W-1:0]   out_resp_id,
    input  logic                out_resp_last,
    input  logic [RESP_W-1:0]   out_resp_bits,
    output logic                in_resp_valid,
    input  logic                in_resp_ready,
    output logic [IN_ID_W-1:0]  in_resp_id,
    output logic                in_resp_last,
    output logic [RESP_W-1:0]   in_resp_bits,
    output logic                err_underflow
`ifdef AXI4_ID_COMPACTOR_STATS_EN
    ,
    output logic [15:0]         stall_cnt
`endif
);

    localparam int NUM_SLOTS = 2 ** SLOT_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0]   cnt [NUM_SLOTS];
    logic [IN_ID_W-1:0] tag [NUM_SLOTS];

    logic               hit;
    logic [SLOT_W-1:0]  hit_idx;
    logic               free_found;
    logic [SLOT_W-1:0]  free_idx;
    logic               accept;
    logic [SLOT_W-1:0]  sel;
    logic               req_fire;
    logic               resp_done;

    // Lookup uses registered counts only, so a slot freed by a response in
    // this cycle cannot be reallocated until the next one. Walking from the
    // top down leaves the lowest matching index in the result.
    always_comb begin
        hit        = 1'b0;
        hit_idx    = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (cnt[i] != '0 && tag[i] == in_req_id) begin
                hit     = 1'b1;
                hit_idx = SLOT_W'(i);
            end
            if (cnt[i] == '0) begin
                free_found = 1'b1;
                free_idx   = SLOT_W'(i);
            end
        end
    end

    // An ID already in flight must stay on its slot, even if that slot is
    // full; stalling preserves response ordering for that ID.
    assign accept = hit ? (cnt[hit_idx] != CNT_MAX) : free_found;
    assign sel    = hit ? hit_idx : free_idx;

    assign out_req_valid = in_req_valid & accept & reset_n;
    assign in_req_ready  = out_req_ready & accept & reset_n;
    assign out_req_id    = sel;
    assign out_req_bits  = in_req_bits;
    assign req_fire      = out_req_valid & out_req_ready;

    assign in_resp_valid  = out_resp_valid;
    assign out_resp_ready = in_resp_ready;
    assign in_resp_id     = tag[out_resp_id];
    assign in_resp_last   = out_resp_last;
    assign in_resp_bits   = out_resp_bits;
    assign resp_done      = out_resp_valid & in_resp_ready & out_resp_last;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                cnt[i] <= '0;
                tag[i] <= '0;
            end
            err_underflow <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                logic inc;
                logic dec;
                inc = req_fire && (sel == SLOT_W'(i));
                // A last beat on an idle slot is a protocol error; the count
                // must not wrap.
                dec = resp_done && (out_resp_id == SLOT_W'(i)) && (cnt[i] != '0);
                if (inc && !dec) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end else if (dec && !inc) begin
                    cnt[i] <= cnt[i] - 1'b1;
                end
                if (inc && cnt[i] == '0) begin
                    tag[i] <= in_req_id;
                end
            end
            if (resp_done && cnt[out_resp_id] == '0) begin
                err_underflow <= 1'b1;
            end
        end
    end

`ifdef AXI4_ID_COMPACTOR_STATS_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
        end else if (in_req_valid && !accept && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_axi4_id_compactor.sv
// Directed testbench for axi4_id_compactor. Inputs change on the falling
// edge; combinational outputs are sampled 1ns later, before the rising edge.
module tb_axi4_id_compactor;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_req_valid;
    logic        in_req_ready;
    logic [6:0]  in_req_id;
    logic [31:0] in_req_bits;
    logic        out_req_valid;
    logic        out_req_ready;
    logic [1:0]  out_req_id;
    logic [31:0] out_req_bits;
    logic        out_resp_valid;
    logic        out_resp_ready;
    logic [1:0]  out_resp_id;
    logic        out_resp_last;
    logic [33:0] out_resp_bits;
    logic        in_resp_valid;
    logic        in_resp_ready;
    logic [6:0]  in_resp_id;
    logic        in_resp_last;
    logic [33:0] in_resp_bits;
    logic        err_underflow;
`ifdef AXI4_ID_COMPACTOR_STATS_EN
    logic [15:0] stall_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    axi4_id_compactor dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .in_req_valid   (in_req_valid),
        .in_req_ready   (in_req_ready),
        .in_req_id      (in_req_id),
        .in_req_bits    (in_req_bits),
        .out_req_valid  (out_req_valid),
        .out_req_ready  (out_req_ready),
        .out_req_id     (out_req_id),
        .out_req_bits   (out_req_bits),
        .out_resp_valid (out_resp_valid),
        .out_resp_ready (out_resp_ready),
        .out_resp_id    (out_resp_id),
        .out_resp_last  (out_resp_last),
        .out_resp_bits  (out_resp_bits),
        .in_resp_valid  (in_resp_valid),
        .in_resp_ready  (in_resp_ready),
        .in_resp_id     (in_resp_id),
        .in_resp_last   (in_resp_last),
        .in_resp_bits   (in_resp_bits),
        .err_underflow  (err_underflow)
`ifdef AXI4_ID_COMPACTOR_STATS_EN
        ,
        .stall_cnt      (stall_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic idle();
        in_req_valid   = 1'b0;
        out_resp_valid = 1'b0;
        out_resp_last  = 1'b0;
    endtask

    // Single request cycle; if accepted it fires on the next rising edge.
    task automatic req(input logic [6:0] id, input logic exp_rdy,
                       input logic [1:0] exp_slot, input string tag);
        in_req_valid = 1'b1;
        in_req_id    = id;
        #1;
        chk({tag, ".rdy"}, in_req_ready, exp_rdy);
        chk({tag, ".vld"}, out_req_valid, exp_rdy);
        if (exp_rdy) chk({tag, ".slot"}, out_req_id, exp_slot);
        step();
        in_req_valid = 1'b0;
    endtask

    task automatic resp(input logic [1:0] slot, input logic last,
                        input logic [6:0] exp_id, input string tag);
        out_resp_valid = 1'b1;
        out_resp_id    = slot;
        out_resp_last  = last;
        #1;
        chk({tag, ".rid"}, in_resp_id, exp_id);
        step();
        out_resp_valid = 1'b0;
        out_resp_last  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n        = 1'b0;
        in_req_valid   = 1'b1;
        in_req_id      = 7'h25;
        in_req_bits    = 32'hDEADBEEF;
        out_req_ready  = 1'b1;
        out_resp_valid = 1'b0;
        out_resp_id    = 2'd0;
        out_resp_last  = 1'b0;
        out_resp_bits  = 34'h2_1234_5678;
        in_resp_ready  = 1'b1;
        @(negedge clock);
        #1;
        chk("rst.out_req_valid", out_req_valid, 0);
        chk("rst.in_req_ready", in_req_ready, 0);
        chk("rst.err", err_underflow, 0);
        chk("rst.resp_id", in_resp_id, 0);
        @(negedge clock);
        reset_n = 1'b1;
        idle();
        step();

        // basic mapping and passthrough
        in_req_valid = 1'b1;
        #1;
        chk("pass.req_bits", out_req_bits, 32'hDEADBEEF);
        in_req_valid = 1'b0;
        req(7'h25, 1, 0, "basic.req");
        out_resp_valid = 1'b1;
        #1;
        chk("pass.resp_bits", in_resp_bits, 34'h2_1234_5678);
        chk("pass.resp_valid", in_resp_valid, 1);
        out_resp_valid = 1'b0;
        resp(0, 1, 7'h25, "basic.resp");
        req(7'h40, 1, 0, "basic.reuse");
        resp(0, 1, 7'h40, "basic.drain");

        // same-ID ordering
        for (int i = 0; i < 3; i++) req(7'h11, 1, 0, "same.req");
        req(7'h12, 1, 1, "same.other");
        for (int i = 0; i < 3; i++) resp(0, 1, 7'h11, "same.drain0");
        resp(1, 1, 7'h12, "same.drain1");

        // slot exhaustion
        for (int i = 0; i < 4; i++) req(7'(i + 1), 1, 2'(i), "exh.fill");
        req(7'h05, 0, 0, "exh.stall");
        in_req_valid = 1'b1;
        in_req_id    = 7'h05;
        out_resp_valid = 1'b1;
        out_resp_id    = 2'd2;
        out_resp_last  = 1'b1;
        #1;
        chk("exh.same_cyc_rdy", in_req_ready, 0);
        chk("exh.same_cyc_rid", in_resp_id, 7'h03);
        step();
        out_resp_valid = 1'b0;
        out_resp_last  = 1'b0;
        req(7'h05, 1, 2, "exh.accept");
        resp(0, 1, 7'h01, "exh.d0");
        resp(1, 1, 7'h02, "exh.d1");
        resp(2, 1, 7'h05, "exh.d2");
        resp(3, 1, 7'h04, "exh.d3");

        // per-ID saturation
        for (int i = 0; i < 7; i++) req(7'h30, 1, 0, "sat.fill");
        req(7'h30, 0, 0, "sat.8th_stall");
        in_req_valid   = 1'b1;
        in_req_id      = 7'h30;
        out_resp_valid = 1'b1;
        out_resp_id    = 2'd0;
        out_resp_last  = 1'b1;
        #1;
        chk("sat.same_cyc_rdy", in_req_ready, 0);
        step();
        out_resp_valid = 1'b0;
        out_resp_last  = 1'b0;
        req(7'h30, 1, 0, "sat.8th_accept");
        req(7'h30, 0, 0, "sat.full_again");
        for (int i = 0; i < 7; i++) resp(0, 1, 7'h30, "sat.drain");
        chk("sat.no_underflow", err_underflow, 0);
        req(7'h31, 1, 0, "sat.slot0_free");
        resp(0, 1, 7'h31, "sat.d31");

        // simultaneous request and last-response on one slot, non-last beat
        req(7'h50, 1, 0, "sim.s0");
        req(7'h51, 1, 1, "sim.s1a");
        req(7'h51, 1, 1, "sim.s1b");
        in_req_valid   = 1'b1;
        in_req_id      = 7'h51;
        out_resp_valid = 1'b1;
        out_resp_id    = 2'd1;
        out_resp_last  = 1'b1;
        #1;
        chk("sim.rdy", in_req_ready, 1);
        chk("sim.slot", out_req_id, 1);
        chk("sim.rid", in_resp_id, 7'h51);
        step();
        idle();
        out_resp_valid = 1'b1;
        #1;
        chk("sim.nonlast_flag", in_resp_last, 0);
        out_resp_valid = 1'b0;
        resp(1, 0, 7'h51, "sim.nonlast");
        resp(1, 1, 7'h51, "sim.dec1");
        resp(1, 1, 7'h51, "sim.dec2");
        chk("sim.no_underflow", err_underflow, 0);
        req(7'h52, 1, 1, "sim.slot1_free");
        resp(1, 1, 7'h52, "sim.d52");
        resp(0, 1, 7'h50, "sim.d50");

        // underflow, then reset mid-traffic
        chk("uf.before", err_underflow, 0);
        resp(3, 1, 7'h04, "uf.resp");
        chk("uf.sticky", err_underflow, 1);
        step();
        chk("uf.sticky2", err_underflow, 1);
        req(7'h60, 1, 0, "uf.a");
        req(7'h61, 1, 1, "uf.b");
        req(7'h62, 1, 2, "uf.c");
        req(7'h63, 1, 3, "uf.slot3_free");
        in_req_valid = 1'b1;
        in_req_id    = 7'h70;
        #1;
        chk("uf.all_busy", in_req_ready, 0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst2.err", err_underflow, 0);
        chk("rst2.out_req_valid", out_req_valid, 0);
        chk("rst2.in_req_ready", in_req_ready, 0);
        out_resp_id = 2'd3;
        #1;
        chk("rst2.tag_clear", in_resp_id, 0);
        idle();
        @(negedge clock);
        reset_n = 1'b1;
        step();
        req(7'h70, 1, 0, "rst2.free0");
        req(7'h71, 1, 1, "rst2.free1");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
